control_fetch_unit: RTL and testbench
=====================================

# control_fetch_unit

Parametrised multi-cycle control unit with an integrated instruction memory, superseding the fixed 1K×16 memory-plus-combinational-control pairing. Owns the PC and the instruction register (IR), and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. Emits per-state datapath control strobes. Adds a memory-load mode, stall, branch/jump PC update and illegal-opcode halt. Sits between the program loader/testbench and the processor datapath.

## Interface
- ADDR_W, 10: instruction address width; depth = 2^ADDR_W; ADDR_W ≤ 12.
- DATA_W, 16: instruction width.
- OPC_W, 4: opcode field width, taken from instr[DATA_W-1 -: OPC_W]; IMM field is instr[11:0].

- CLK in 1: single clock, rising edge.
- RESET in 1: asynchronous, active-low reset.
- load_en in 1: 1 = program-load mode; FSM forced to IDLE.
- wea in 1: memory write strobe; effective only when load_en=1.
- addra in ADDR_W: load address.
- dina in DATA_W: load data.
- stall in 1: freeze FSM, PC and IR.
- zero in 1: ALU zero flag, sampled in EXEC of BEQ.
- pc out ADDR_W: current PC.
- instr out DATA_W: IR contents.
- ALUSrc, MemtoReg, RegDst, RegWrite, MemRead, MemWrite, Branch out 1 each: datapath controls.
- illegal out 1: sticky illegal-opcode flag.
- state out 3: FSM state code, for debug.

## Operation
- Opcodes:
  - 0 R-type
  - 1 BEQ
  - 2 LW
  - 3 SW
  - 4 ADDI
  - 5 J
  - 6–15 illegal
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE→FETCH when load_en=0.
- FETCH: memory address = pc. →DECODE.
- DECODE: memory dout is valid. IR ← dout and pc ← pc+1 on the exit edge. →EXEC, or →HALT if the opcode is illegal; pc still increments in that case.
- EXEC:
  - ALUSrc=1 for LW, SW and ADDI.
  - Branch=1 for BEQ; if zero=1, pc ← pc + sext(IMM) truncated to ADDR_W.
  - J: pc ← IMM[ADDR_W-1:0].
  - Next state: R/ADDI→WB; LW/SW→MEM; BEQ/J→FETCH.
- MEM: MemRead=1 (LW) or MemWrite=1 (SW). LW→WB, SW→FETCH.
- WB: RegWrite=1; MemtoReg=1 for LW; RegDst=1 for R-type. →FETCH.
- HALT: illegal=1, all other controls 0. Exit only via reset or load_en=1.
- Control outputs are decoded from state + IR only (Moore). All controls are 0 outside the listed cases.
- stall=1: state, pc and IR hold, and outputs stay at their current-state values. stall is ignored in IDLE and HALT.
- load_en=1 in any state: next edge goes to IDLE, pc ← 0, illegal ← 0, IR holds.
  - Writes happen only when load_en=1 and wea=1.
  - Memory address is addra while load_en=1, otherwise pc.
- PC arithmetic is modulo 2^ADDR_W. Increment from all-ones wraps to 0, and branch targets wrap the same way.
- Simultaneous load_en and stall: load_en wins.

## Timing
- Reset (RESET=0, asynchronous): state=IDLE, pc=0, IR=0, illegal=0, all controls 0.
- Memory read is synchronous with 1-cycle latency: address in FETCH, data in DECODE.
- Cycles per instruction with no stall:
  - BEQ/J: 3
  - SW/R/ADDI: 4
  - LW: 5
- A memory write issued on edge n is readable by a FETCH issued from edge n+1 onward.
- Reset asserted mid-instruction aborts immediately. No partial strobe survives the reset.

## Structure
- Package ctrl_pkg holds:
  - opcode localparams OP_R, OP_BEQ, OP_LW, OP_SW, OP_ADDI, OP_J
  - state encoding typedef ctrl_state_t (3-bit)
  - the IMM field position
- Sub-module instr_mem: single-port synchronous RAM, ADDR_W × DATA_W, with write enable and registered read. Inferred; no vendor IP.
- Top holds the FSM, the PC/IR registers and the output decode.

## Test plan
- Load program: mem[0]=0x0123 (R), mem[1]=0x1003 (BEQ +3), mem[5]=0x2010 (LW), mem[6]=0x3010 (SW), mem[7]=0x5000 (J 0). Drop load_en → R path IDLE,F,D,E,WB with RegWrite=RegDst=1 only in WB; pc=1 after DECODE.
- BEQ at pc=1 with zero=1 → Branch=1 in EXEC, pc=5 at the next FETCH. Repeat with zero=0 → pc=2.
- LW at 5 → MemRead=1 in MEM, then RegWrite=MemtoReg=1 in WB, 5 cycles total. SW at 6 → MemWrite=1 in MEM, then FETCH; RegWrite never asserts.
- J at 7 → pc=0. Place J at 0x3FF with PC increment wrap check: executing 0x3FF increments pc to 0x000 before EXEC.
- stall=1 for 3 cycles during MEM of LW → MemRead is held high 4 cycles; pc and state are unchanged.
- mem[0]=0xF000 → illegal=1 and HALT after DECODE. RESET low mid-EXEC → all outputs 0 and pc=0 asynchronously. load_en=1 in HALT → IDLE and illegal=0 next edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control/fetch unit: opcodes, FSM
// state encoding and the immediate field position.
package ctrl_pkg;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_BEQ  = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_J    = 4'd5;

    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } ctrl_state_t;

endpackage

// File: rtl/instr_mem.sv
// Single-port instruction RAM with registered read (one cycle latency).
// Read returns the old contents when reading and writing the same address.
module instr_mem #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_dout;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_din;
        end
        r_dout <= r_mem[i_addr];
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/control_fetch_unit.sv
// Multi-cycle control unit: owns PC and IR, sequences FETCH/DECODE/EXEC/MEM/WB
// over an integrated instruction RAM and emits Moore datapath control strobes.
//
// state  | meaning
// IDLE   | program-load mode or waiting for load_en to drop
// FETCH  | RAM addressed with pc
// DECODE | RAM data valid; IR and pc+1 captured on exit
// EXEC   | ALU step; BEQ/J resolve the next pc here
// MEM    | data memory access for LW/SW
// WB     | register file write-back
// HALT   | illegal opcode seen; left only by reset or load_en
module control_fetch_unit
    import ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int OPC_W  = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load_en,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    input  logic              stall,
    input  logic              zero,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              ALUSrc,
    output logic              MemtoReg,
    output logic              RegDst,
    output logic              RegWrite,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              Branch,
    output logic              illegal,
    output logic [2:0]        state
);

    ctrl_state_t       r_state, w_next_state;
    logic [ADDR_W-1:0] r_pc, w_next_pc;
    logic [DATA_W-1:0] r_ir, w_next_ir;
    logic              r_illegal, w_next_illegal;

    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_dout;
    logic [OPC_W-1:0]  w_ir_opc, w_dout_opc;
    logic [ADDR_W-1:0] w_imm_addr;

    assign w_mem_addr = load_en ? addra : r_pc;
    assign w_ir_opc   = r_ir[DATA_W-1 -: OPC_W];
    assign w_dout_opc = w_dout[DATA_W-1 -: OPC_W];
    // With ADDR_W <= IMM_W, sign-extend-then-truncate is just the low IMM bits.
    assign w_imm_addr = r_ir[IMM_LSB +: ADDR_W];

    instr_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_instr_mem (
        .i_clk  (CLK),
        .i_we   (load_en & wea),
        .i_addr (w_mem_addr),
        .i_din  (dina),
        .o_dout (w_dout)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pc      <= w_next_pc;
            r_ir      <= w_next_ir;
            r_illegal <= w_next_illegal;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_pc      = r_pc;
        w_next_ir      = r_ir;
        w_next_illegal = r_illegal;
        if (load_en) begin
            w_next_state   = ST_IDLE;
            w_next_pc      = '0;
            w_next_illegal = 1'b0;
        end else if (stall && (r_state != ST_IDLE) && (r_state != ST_HALT)) begin
            w_next_state = r_state;
        end else begin
            case (r_state)
                ST_IDLE:  w_next_state = ST_FETCH;
                ST_FETCH: w_next_state = ST_DECODE;
                ST_DECODE: begin
                    w_next_ir = w_dout;
                    w_next_pc = r_pc + ADDR_W'(1);
                    if (w_dout_opc > OPC_W'(OP_J)) begin
                        w_next_state   = ST_HALT;
                        w_next_illegal = 1'b1;
                    end else begin
                        w_next_state = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (w_ir_opc)
                        OPC_W'(OP_R), OPC_W'(OP_ADDI): w_next_state = ST_WB;
                        OPC_W'(OP_LW), OPC_W'(OP_SW):  w_next_state = ST_MEM;
                        OPC_W'(OP_BEQ): begin
                            w_next_state = ST_FETCH;
                            if (zero) begin
                                w_next_pc = r_pc + w_imm_addr;
                            end
                        end
                        OPC_W'(OP_J): begin
                            w_next_state = ST_FETCH;
                            w_next_pc    = w_imm_addr;
                        end
                        default: begin
                            w_next_state   = ST_HALT;
                            w_next_illegal = 1'b1;
                        end
                    endcase
                end
                ST_MEM:  w_next_state = (w_ir_opc == OPC_W'(OP_LW)) ? ST_WB : ST_FETCH;
                ST_WB:   w_next_state = ST_FETCH;
                ST_HALT: w_next_state = ST_HALT;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        case (r_state)
            ST_EXEC: begin
                ALUSrc = (w_ir_opc == OPC_W'(OP_LW)) || (w_ir_opc == OPC_W'(OP_SW)) ||
                         (w_ir_opc == OPC_W'(OP_ADDI));
                Branch = (w_ir_opc == OPC_W'(OP_BEQ));
            end
            ST_MEM: begin
                MemRead  = (w_ir_opc == OPC_W'(OP_LW));
                MemWrite = (w_ir_opc == OPC_W'(OP_SW));
            end
            ST_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (w_ir_opc == OPC_W'(OP_LW));
                RegDst   = (w_ir_opc == OPC_W'(OP_R));
            end
            default: ;
        endcase
    end

    assign pc      = r_pc;
    assign instr   = r_ir;
    assign illegal = r_illegal;
    assign state   = r_state;

endmodule

// File: tb/tb_control_fetch_unit.sv
// Scoreboard bench for control_fetch_unit: the driver pushes hand-computed
// per-cycle expectations, a monitor pops and compares them after each negedge.
module tb_control_fetch_unit;
    import ctrl_pkg::*;

    localparam logic [7:0] C_NONE = 8'h00;
    localparam logic [7:0] C_ALU  = 8'h80;
    localparam logic [7:0] C_M2R  = 8'h40;
    localparam logic [7:0] C_RDST = 8'h20;
    localparam logic [7:0] C_RW   = 8'h10;
    localparam logic [7:0] C_MR   = 8'h08;
    localparam logic [7:0] C_MW   = 8'h04;
    localparam logic [7:0] C_BR   = 8'h02;
    localparam logic [7:0] C_ILL  = 8'h01;

    logic        CLK = 1'b0;
    logic        RESET, load_en, wea, stall, zero;
    logic [9:0]  addra;
    logic [15:0] dina;
    logic [9:0]  pc;
    logic [15:0] instr;
    logic        ALUSrc, MemtoReg, RegDst, RegWrite, MemRead, MemWrite, Branch, illegal;
    logic [2:0]  state;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic [9:0]  pc;
        logic [7:0]  ctl;
        logic        chk_ir;
        logic [15:0] ir;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLK = ~CLK;

    control_fetch_unit dut (
        .CLK(CLK), .RESET(RESET), .load_en(load_en), .wea(wea), .addra(addra),
        .dina(dina), .stall(stall), .zero(zero), .pc(pc), .instr(instr),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .illegal(illegal),
        .state(state)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_now(input string n, input ctrl_state_t s, input logic [9:0] p,
                              input logic [7:0] c, input logic ci, input logic [15:0] ir);
        exp_t e;
        e.name = n; e.st = s; e.pc = p; e.ctl = c; e.chk_ir = ci; e.ir = ir;
        sb.push_back(e);
    endtask

    task automatic cyc(input string n, input ctrl_state_t s, input logic [9:0] p,
                       input logic [7:0] c, input logic ci, input logic [15:0] ir);
        step();
        expect_now(n, s, p, c, ci, ir);
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] d);
        addra = a; dina = d; wea = 1'b1;
        step();
        wea = 1'b0;
    endtask

    // Monitor: sampled away from the rising edge; also wakes on async reset.
    initial begin
        exp_t        e;
        logic [7:0]  act_ctl;
        forever begin
            @(negedge CLK or negedge RESET);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                act_ctl = {ALUSrc, MemtoReg, RegDst, RegWrite, MemRead, MemWrite, Branch, illegal};
                n_tests++;
                if (state !== e.st) begin
                    n_fail++;
                    $display("FAIL %s state got %0d want %0d", e.name, state, e.st);
                end
                n_tests++;
                if (pc !== e.pc) begin
                    n_fail++;
                    $display("FAIL %s pc got %h want %h", e.name, pc, e.pc);
                end
                n_tests++;
                if (act_ctl !== e.ctl) begin
                    n_fail++;
                    $display("FAIL %s ctl got %b want %b", e.name, act_ctl, e.ctl);
                end
                if (e.chk_ir) begin
                    n_tests++;
                    if (instr !== e.ir) begin
                        n_fail++;
                        $display("FAIL %s instr got %h want %h", e.name, instr, e.ir);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout sim time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b0; load_en = 1'b1; wea = 1'b0; stall = 1'b0; zero = 1'b0;
        addra = '0; dina = '0;
        #2;
        expect_now("reset", ST_IDLE, 10'h000, C_NONE, 1'b1, 16'h0000);
        step();
        RESET = 1'b1;

        wr(10'h000, 16'h0123);
        wr(10'h001, 16'h1003);
        wr(10'h005, 16'h2010);
        wr(10'h006, 16'h3010);
        wr(10'h007, 16'h5000);
        expect_now("load_idle", ST_IDLE, 10'h000, C_NONE, 1'b0, 16'h0);
        load_en = 1'b0;

        cyc("r_fetch",  ST_FETCH,  10'h000, C_NONE, 1'b0, 16'h0);
        cyc("r_decode", ST_DECODE, 10'h000, C_NONE, 1'b0, 16'h0);
        cyc("r_exec",   ST_EXEC,   10'h001, C_NONE, 1'b1, 16'h0123);
        cyc("r_wb",     ST_WB,     10'h001, C_RW | C_RDST, 1'b0, 16'h0);
        cyc("beq_fetch",  ST_FETCH,  10'h001, C_NONE, 1'b0, 16'h0);
        zero = 1'b1;
        cyc("beq_decode", ST_DECODE, 10'h001, C_NONE, 1'b0, 16'h0);
        cyc("beq_exec",   ST_EXEC,   10'h002, C_BR, 1'b1, 16'h1003);
        cyc("beq_taken",  ST_FETCH,  10'h005, C_NONE, 1'b0, 16'h0);
        zero = 1'b0;
        cyc("lw_decode", ST_DECODE, 10'h005, C_NONE, 1'b0, 16'h0);
        cyc("lw_exec",   ST_EXEC,   10'h006, C_ALU, 1'b1, 16'h2010);
        cyc("lw_mem",    ST_MEM,    10'h006, C_MR, 1'b0, 16'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc("lw_mem_stall", ST_MEM, 10'h006, C_MR, 1'b1, 16'h2010);
        end
        stall = 1'b0;
        cyc("lw_wb",     ST_WB,     10'h006, C_RW | C_M2R, 1'b0, 16'h0);
        cyc("sw_fetch",  ST_FETCH,  10'h006, C_NONE, 1'b0, 16'h0);
        cyc("sw_decode", ST_DECODE, 10'h006, C_NONE, 1'b0, 16'h0);
        cyc("sw_exec",   ST_EXEC,   10'h007, C_ALU, 1'b1, 16'h3010);
        cyc("sw_mem",    ST_MEM,    10'h007, C_MW, 1'b0, 16'h0);
        cyc("j_fetch",   ST_FETCH,  10'h007, C_NONE, 1'b0, 16'h0);
        cyc("j_decode",  ST_DECODE, 10'h007, C_NONE, 1'b0, 16'h0);
        cyc("j_exec",    ST_EXEC,   10'h008, C_NONE, 1'b1, 16'h5000);
        cyc("j_target",  ST_FETCH,  10'h000, C_NONE, 1'b0, 16'h0);
        cyc("r2_decode", ST_DECODE, 10'h000, C_NONE, 1'b0, 16'h0);
        cyc("r2_exec",   ST_EXEC,   10'h001, C_NONE, 1'b1, 16'h0123);
        cyc("r2_wb",     ST_WB,     10'h001, C_RW | C_RDST, 1'b0, 16'h0);
        cyc("beq2_fetch",  ST_FETCH,  10'h001, C_NONE, 1'b0, 16'h0);
        cyc("beq2_decode", ST_DECODE, 10'h001, C_NONE, 1'b0, 16'h0);
        cyc("beq2_exec",   ST_EXEC,   10'h002, C_BR, 1'b1, 16'h1003);
        cyc("beq_not_taken", ST_FETCH, 10'h002, C_NONE, 1'b0, 16'h0);
        load_en = 1'b1;
        cyc("load_from_fetch", ST_IDLE, 10'h000, C_NONE, 1'b1, 16'h1003);

        wr(10'h000, 16'h53FF);
        wr(10'h3FF, 16'h5005);
        expect_now("wrap_idle", ST_IDLE, 10'h000, C_NONE, 1'b0, 16'h0);
        load_en = 1'b0;
        cyc("wrap_f0",   ST_FETCH,  10'h000, C_NONE, 1'b0, 16'h0);
        cyc("wrap_d0",   ST_DECODE, 10'h000, C_NONE, 1'b0, 16'h0);
        cyc("wrap_e0",   ST_EXEC,   10'h001, C_NONE, 1'b1, 16'h53FF);
        cyc("wrap_f3ff", ST_FETCH,  10'h3FF, C_NONE, 1'b0, 16'h0);
        cyc("wrap_d3ff", ST_DECODE, 10'h3FF, C_NONE, 1'b0, 16'h0);
        cyc("wrap_e3ff", ST_EXEC,   10'h000, C_NONE, 1'b1, 16'h5005);
        cyc("wrap_jump", ST_FETCH,  10'h005, C_NONE, 1'b0, 16'h0);
        load_en = 1'b1;
        cyc("wrap_load", ST_IDLE,   10'h000, C_NONE, 1'b0, 16'h0);

        wr(10'h000, 16'hF000);
        expect_now("ill_idle", ST_IDLE, 10'h000, C_NONE, 1'b0, 16'h0);
        load_en = 1'b0;
        cyc("ill_fetch",  ST_FETCH,  10'h000, C_NONE, 1'b0, 16'h0);
        cyc("ill_decode", ST_DECODE, 10'h000, C_NONE, 1'b0, 16'h0);
        cyc("ill_halt",   ST_HALT,   10'h001, C_ILL, 1'b1, 16'hF000);
        stall = 1'b1;
        cyc("ill_halt_stall", ST_HALT, 10'h001, C_ILL, 1'b0, 16'h0);
        stall = 1'b0;
        load_en = 1'b1;
        cyc("ill_clear", ST_IDLE, 10'h000, C_NONE, 1'b1, 16'hF000);

        wr(10'h000, 16'h2010);
        load_en = 1'b0;
        cyc("rst_fetch",  ST_FETCH,  10'h000, C_NONE, 1'b0, 16'h0);
        cyc("rst_decode", ST_DECODE, 10'h000, C_NONE, 1'b0, 16'h0);
        cyc("rst_exec",   ST_EXEC,   10'h001, C_ALU, 1'b1, 16'h2010);
        @(negedge CLK);
        #3;
        expect_now("async_rst", ST_IDLE, 10'h000, C_NONE, 1'b1, 16'h0000);
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        cyc("post_rst_fetch", ST_FETCH, 10'h000, C_NONE, 1'b0, 16'h0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
        #2;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending %0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
